alu_mc: RTL

Parametrised, multi-cycle successor to the 4-bit two-function ALU. Eight operations on WIDTH-bit operands, including an iterative shift-add multiply. Operands enter and results leave through valid/ready handshakes. The result and the Z/C/N/V flags are registered, so the block can sit directly between the register-file read stage and the writeback stage of the CPU datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_mc.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for alu_mc.
package alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_NAND = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_MUL  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Flag register is packed as {Z,C,N,V}.
   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial-product step per step_i cycle.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   output logic                 done_o,
   output logic [2*WIDTH-1:0]   prod_o
);

   localparam int unsigned CntW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] step_prod;

   // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
   always_comb begin
      sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
      step_prod = {sum, prod_q[WIDTH-1:1]};
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      cnt_d     = cnt_q;
      if (start_i) begin
         mcand_d = a_i;
         prod_d  = {{WIDTH{1'b0}}, b_i};
         cnt_d   = '0;
      end else if (step_i) begin
         prod_d = step_prod;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   // done_o flags the final step; prod_o is the product that step produces.
   assign done_o = step_i && (cnt_q == CntW'(WIDTH - 1));
   assign prod_o = step_prod;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         mcand_q <= mcand_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle eight-op ALU with valid/ready handshakes and registered result/flags.
module alu_mc
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] RES,
   output logic [WIDTH-1:0] RES_HI,
   output logic             Z,
   output logic             C,
   output logic             N,
   output logic             V
);

   localparam int unsigned ShW = $clog2(WIDTH);
   localparam int unsigned Msb = WIDTH - 1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   res_q, res_d, hi_q, hi_d;
   logic [3:0]         flags_q, flags_d;

   logic [WIDTH:0]     add_sum, sub_sum;
   logic [2*WIDTH-1:0] shl_ext;
   logic [WIDTH-1:0]   core_res;
   logic               core_c, core_v;

   logic               mul_start, mul_step, mul_done;
   logic [2*WIDTH-1:0] mul_prod;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (mul_start),
      .step_i  (mul_step),
      .a_i     (A),
      .b_i     (B),
      .done_o  (mul_done),
      .prod_o  (mul_prod)
   );

   // Bit WIDTH of the widened shift is the last bit pushed out (0 when shift is 0).
   always_comb begin
      add_sum  = {1'b0, A} + {1'b0, B};
      sub_sum  = {1'b0, A} + {1'b0, ~B} + 1'b1;
      shl_ext  = {{WIDTH{1'b0}}, A} << B[ShW-1:0];
      core_res = '0;
      core_c   = 1'b0;
      core_v   = 1'b0;
      case (sel)
         OP_ADD: begin
            core_res = add_sum[WIDTH-1:0];
            core_c   = add_sum[WIDTH];
            core_v   = (A[Msb] == B[Msb]) && (core_res[Msb] != A[Msb]);
         end
         OP_SUB: begin
            core_res = sub_sum[WIDTH-1:0];
            core_c   = sub_sum[WIDTH];
            core_v   = (A[Msb] != B[Msb]) && (core_res[Msb] != A[Msb]);
         end
         OP_NAND: core_res = ~(A & B);
         OP_AND:  core_res = A & B;
         OP_OR:   core_res = A | B;
         OP_XOR:  core_res = A ^ B;
         OP_SHL: begin
            core_res = shl_ext[WIDTH-1:0];
            core_c   = shl_ext[WIDTH];
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      res_d     = res_q;
      hi_d      = hi_q;
      flags_d   = flags_q;
      mul_start = 1'b0;
      mul_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               if (sel == OP_MUL) begin
                  state_d   = ST_BUSY;
                  mul_start = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  res_d   = core_res;
                  hi_d    = '0;
                  flags_d = {core_res == '0, core_c, core_res[Msb], core_v};
               end
            end
         end
         ST_BUSY: begin
            mul_step = 1'b1;
            if (mul_done) begin
               state_d = ST_DONE;
               hi_d    = mul_prod[2*WIDTH-1:WIDTH];
               res_d   = mul_prod[WIDTH-1:0];
               flags_d = {mul_prod[WIDTH-1:0] == '0, |mul_prod[2*WIDTH-1:WIDTH],
                          mul_prod[Msb], 1'b0};
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         hi_q    <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         hi_q    <= hi_d;
         flags_q <= flags_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE) && rst_n;
   assign out_valid = (state_q == ST_DONE);
   assign RES       = res_q;
   assign RES_HI    = hi_q;
   assign Z         = flags_q[FLAG_Z];
   assign C         = flags_q[FLAG_C];
   assign N         = flags_q[FLAG_N];
   assign V         = flags_q[FLAG_V];

endmodule
